// File: rtl/qdac_sar_if.sv
// qdac_sar_if
//   Bundles the conversion handshake and QDAC frame signals of the SAR
//   sequencer.
//   slave  modport : sequencer side. It receives start/abort/cmp_in and drives
//                    code/qdac_rst/busy/done/result.
//   master modport : requester/analog side, with the opposite directions.
//   Signals:
//     start    request a conversion; sampled only while idle
//     abort    synchronous cancel of any activity
//     cmp_in   comparator decision, 1 = QDAC Vout above the input
//     code     NBITS-wide QDAC code bus (MSB = code[NBITS-1])
//     qdac_rst QDAC capacitor reset switch drive
//     busy     conversion in progress
//     done     one-cycle result-valid pulse
//     result   last completed conversion result
interface qdac_sar_if #(
  parameter int NBITS = 5
);
  logic             start;
  logic             abort;
  logic             cmp_in;
  logic [NBITS-1:0] code;
  logic             qdac_rst;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;

  modport slave (
    input  start, abort, cmp_in,
    output code, qdac_rst, busy, done, result
  );

  modport master (
    output start, abort, cmp_in,
    input  code, qdac_rst, busy, done, result
  );
endinterface

// File: rtl/qdac_sar_controller.sv
// qdac_sar_controller
//   Successive-approximation sequencer for the 5-bit capacitive QDAC. It
//   resets the QDAC capacitors and then resolves one code bit at a time by
//   binary search, using the comparator decision on the QDAC output.
//
//   Ports:
//     clk  conversion clock
//     rst  asynchronous active-high reset
//     bus  qdac_sar_if.slave: start, abort, cmp_in in; code, qdac_rst, busy,
//          done, result out. All outputs come straight from flops.
//
//   Parameters:
//     NBITS          conversion width (number of QDAC code bits)
//     RST_CYCLES     cycles qdac_rst is held high at the start of a conversion
//     SETTLE_CYCLES  settling cycles after each trial-bit change
//
//   Build option:
//     QDAC_SAR_CMP_SYNC_EN  when defined, cmp_in passes through a 2-flop
//                           synchronizer, which adds 2 cycles to every bit
//                           trial. When undefined, cmp_in must already be
//                           synchronous to clk.
module qdac_sar_controller #(
  parameter int NBITS         = 5,
  parameter int RST_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         rst,
  qdac_sar_if.slave    bus
);

`ifdef QDAC_SAR_CMP_SYNC_EN
  localparam int SYNC_STAGES = 2;
`else
  localparam int SYNC_STAGES = 0;
`endif

  // Cycles spent on each trial bit; the comparator is sampled on the last edge.
  localparam int HOLD    = 1 + SETTLE_CYCLES + SYNC_STAGES;
  localparam int CNT_MAX = (RST_CYCLES > HOLD) ? RST_CYCLES : HOLD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_BIT   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [NBITS-1:0] code_q, code_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             qdac_rst_q, qdac_rst_d;
  logic             done_q, done_d;
  logic             cmp_s;
  logic             bit_last;

  // Comparator path
`ifdef QDAC_SAR_CMP_SYNC_EN
  logic cmp_meta_q, cmp_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_meta_q <= 1'b0;
      cmp_sync_q <= 1'b0;
    end else begin
      cmp_meta_q <= bus.cmp_in;
      cmp_sync_q <= cmp_meta_q;
    end
  end

  assign cmp_s = cmp_sync_q;
`else
  assign cmp_s = bus.cmp_in;
`endif

  // The trial value is too high when the comparator reports 1, so that bit is dropped.
  function automatic logic [NBITS-1:0] apply_decision(input logic [NBITS-1:0] code,
                                                      input logic [IDX_W-1:0] idx,
                                                      input logic             cmp);
    logic [NBITS-1:0] c;
    c = code;
    if (cmp) c[idx] = 1'b0;
    return c;
  endfunction

  assign bit_last = (cnt_q == CNT_W'(HOLD - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      code_q     <= '0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      qdac_rst_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      code_q     <= code_d;
      result_q   <= result_d;
      busy_q     <= busy_d;
      qdac_rst_q <= qdac_rst_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. abort overrides every transition, including start in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_RESET;
            cnt_d   = '0;
          end
        end
        S_RESET: begin
          if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
            state_d = S_BIT;
            cnt_d   = '0;
            idx_d   = IDX_W'(NBITS - 1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_BIT: begin
          if (bit_last) begin
            cnt_d = '0;
            if (idx_q == '0) state_d = S_DONE;
            else             idx_d   = idx_q - IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: computes the next values of the registered outputs.
  always_comb begin
    code_d     = code_q;
    result_d   = result_q;
    busy_d     = 1'b0;
    qdac_rst_d = 1'b1;
    done_d     = 1'b0;
    unique case (state_d)
      S_IDLE: begin
        code_d = '0;
      end
      S_RESET: begin
        code_d = '0;
        busy_d = 1'b1;
      end
      S_BIT: begin
        busy_d     = 1'b1;
        qdac_rst_d = 1'b0;
        if (state_q == S_RESET) begin
          code_d = NBITS'(1) << (NBITS - 1);
        end else if (bit_last) begin
          // Resolve the current bit and raise the next trial bit on the same edge.
          code_d = apply_decision(code_q, idx_q, cmp_s) | (NBITS'(1) << idx_d);
        end
      end
      S_DONE: begin
        qdac_rst_d = 1'b0;
        done_d     = 1'b1;
        code_d     = apply_decision(code_q, idx_q, cmp_s);
        result_d   = apply_decision(code_q, idx_q, cmp_s);
      end
      default: code_d = '0;
    endcase
  end

  assign bus.code     = code_q;
  assign bus.result   = result_q;
  assign bus.busy     = busy_q;
  assign bus.qdac_rst = qdac_rst_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_qdac_sar_controller.sv
module tb_qdac_sar_controller;

`ifdef QDAC_SAR_CMP_SYNC_EN
  localparam int S   = 2;
  localparam int LAT = 29;
`else
  localparam int S   = 0;
  localparam int LAT = 19;
`endif
  localparam int HOLD = 3 + S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmp_mode = 0;   // 0: cmp = (code > 19), 1: stuck 1, 2: stuck 0
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  qdac_sar_if #(.NBITS(5)) sif ();

  qdac_sar_controller #(
    .NBITS(5), .RST_CYCLES(4), .SETTLE_CYCLES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  assign sif.cmp_in = (cmp_mode == 0) ? (sif.code > 5'd19) : (cmp_mode == 1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Runs one conversion from a one-cycle start pulse. Optionally checks the
  // model trial codes and pulses start again at edge pulse_at (0 = never).
  task automatic run_conv(input string tag, input logic [4:0] exp_res,
                          input int with_trials, input int pulse_at);
    logic [4:0] trials [5];
    int done_cnt;
    int done_at;
    trials[0] = 5'd16; trials[1] = 5'd24; trials[2] = 5'd20;
    trials[3] = 5'd18; trials[4] = 5'd19;
    done_cnt = 0;
    done_at  = -1;
    sif.start = 1'b1;
    tick();                        // edge 0: start accepted
    sif.start = 1'b0;
    chk({tag, "_busy_e0"}, {31'd0, sif.busy}, 32'd1);
    for (int k = 1; k <= LAT + 4; k++) begin
      sif.start = (pulse_at != 0 && k == pulse_at);
      tick();
      if (sif.done) begin
        done_cnt++;
        done_at = k;
      end
      if (with_trials != 0) begin
        for (int b = 0; b < 5; b++)
          if (k == 4 + b * HOLD) begin
            chk($sformatf("%s_trial%0d", tag, b), {27'd0, sif.code}, {27'd0, trials[b]});
            chk($sformatf("%s_qrst%0d", tag, b), {31'd0, sif.qdac_rst}, 32'd0);
          end
      end
    end
    sif.start = 1'b0;
    chk({tag, "_done_cnt"}, done_cnt, 32'd1);
    chk({tag, "_done_at"}, done_at, LAT);
    chk({tag, "_result"}, {27'd0, sif.result}, {27'd0, exp_res});
    chk({tag, "_busy_end"}, {31'd0, sif.busy}, 32'd0);
    chk({tag, "_code_end"}, {27'd0, sif.code}, 32'd0);
  endtask

  initial begin
    int done_cnt;
    int done_a;
    int done_b;
    sif.start = 1'b0;
    sif.abort = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_code", {27'd0, sif.code}, 32'd0);
    chk("rst_qrst", {31'd0, sif.qdac_rst}, 32'd1);
    chk("rst_busy", {31'd0, sif.busy}, 32'd0);
    chk("rst_done", {31'd0, sif.done}, 32'd0);
    chk("rst_result", {27'd0, sif.result}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", {31'd0, sif.busy}, 32'd0);

    // Model comparator: trials 16,24,20,18,19 -> 19
    cmp_mode = 0;
    run_conv("model", 5'd19, 1, 0);

    // Stuck comparators
    cmp_mode = 1;
    run_conv("stuck1", 5'd0, 0, 0);
    cmp_mode = 2;
    run_conv("stuck0", 5'd31, 0, 0);

    // Abort at edge 10 keeps the previous result (31)
    cmp_mode = 0;
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    sif.abort = 1'b1;
    tick();
    sif.abort = 1'b0;
    chk("abort_busy", {31'd0, sif.busy}, 32'd0);
    chk("abort_code", {27'd0, sif.code}, 32'd0);
    chk("abort_qrst", {31'd0, sif.qdac_rst}, 32'd1);
    chk("abort_result", {27'd0, sif.result}, 32'd31);
    done_cnt = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      if (sif.done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 32'd0);

    // start and abort together in IDLE: stay idle
    sif.start = 1'b1;
    sif.abort = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.abort = 1'b0;
    chk("start_abort_busy", {31'd0, sif.busy}, 32'd0);
    tick();
    chk("start_abort_busy2", {31'd0, sif.busy}, 32'd0);

    // Start pulse mid-BIT is neither obeyed nor queued
    run_conv("midstart", 5'd19, 0, 12);

    // start held high: back-to-back conversions with one idle cycle between
    sif.start = 1'b1;
    tick();
    done_cnt = 0;
    done_a = -1;
    done_b = -1;
    for (int k = 1; k <= 2 * LAT + 2; k++) begin
      tick();
      if (k == LAT + 1) chk("b2b_gap_busy", {31'd0, sif.busy}, 32'd0);
      if (k == LAT + 2) chk("b2b_restart_busy", {31'd0, sif.busy}, 32'd1);
      if (sif.done) begin
        done_cnt++;
        if (done_cnt == 1) done_a = k;
        else               done_b = k;
      end
    end
    sif.start = 1'b0;
    chk("b2b_done_cnt", done_cnt, 32'd2);
    chk("b2b_done_a", done_a, LAT);
    chk("b2b_done_b", done_b, 2 * LAT + 2);
    chk("b2b_result", {27'd0, sif.result}, 32'd19);
    for (int k = 0; k < 4; k++) tick();

    // Asynchronous reset mid-BIT (edge 12)
    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("pre_rst_busy", {31'd0, sif.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_code", {27'd0, sif.code}, 32'd0);
    chk("arst_qrst", {31'd0, sif.qdac_rst}, 32'd1);
    chk("arst_busy", {31'd0, sif.busy}, 32'd0);
    chk("arst_result", {27'd0, sif.result}, 32'd0);
    tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      tick();
      if (sif.done) done_cnt++;
    end
    chk("arst_no_done", done_cnt, 32'd0);
    chk("arst_idle_busy", {31'd0, sif.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
